key_matrix_scanner: RTL



---
 rtl/key_matrix_pkg.sv | 49 ++++
 rtl/key_matrix_scanner_if.sv | 31 +++
 rtl/key_matrix_scanner_frame_debouncer.sv | 86 ++++++++
 rtl/key_matrix_scanner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/key_matrix_pkg.sv
// ---------------------------------------------------------------------------
// key_matrix_pkg
// Shared constants and helpers for the 4x4 key matrix scanner. The row strobe
// encoding and the key index layout (row*COLS+col) are the same as the ones
// used by the row-scanned LED display driver, so pixel N and key N line up.
//
// Contents:
//   ROWS, COLS, NUM_KEYS    matrix geometry
//   ROW_IDX_W, KEY_IDX_W    index widths
//   row_strobe()            row index -> active-low one-hot row drive
//   lowest_set()            index of the lowest set bit of a key mask
//   key_onehot()            key index -> one-hot key mask
// ---------------------------------------------------------------------------
package key_matrix_pkg;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int NUM_KEYS  = ROWS * COLS;
  localparam int ROW_IDX_W = 2;
  localparam int KEY_IDX_W = 4;

  // Active-low one-hot row drive: bit r low selects row r.
  function automatic logic [ROWS-1:0] row_strobe(input logic [ROW_IDX_W-1:0] row);
    logic [ROWS-1:0] strobe;
    strobe      = {ROWS{1'b1}};
    strobe[row] = 1'b0;
    return strobe;
  endfunction

  // Lowest set bit wins; an empty mask returns index 0.
  function automatic logic [KEY_IDX_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] mask);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = KEY_IDX_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [KEY_IDX_W-1:0] idx);
    logic [NUM_KEYS-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/key_matrix_scanner_if.sv
// ---------------------------------------------------------------------------
// key_matrix_scanner_if
// Key event handshake between the scanner (master) and the consumer (slave).
//   key_valid  master->slave  event available
//   key_code   master->slave  key index row*COLS+col
//   key_press  master->slave  1 = press, 0 = release
//   key_ready  slave->master  event accepted when high with key_valid at a clk edge
// ---------------------------------------------------------------------------
interface key_matrix_scanner_if;
  import key_matrix_pkg::*;

  logic                 key_valid;
  logic [KEY_IDX_W-1:0] key_code;
  logic                 key_press;
  logic                 key_ready;

  modport master (
    output key_valid,
    output key_code,
    output key_press,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_press,
    output key_ready
  );

endinterface

// File: rtl/key_matrix_scanner_frame_debouncer.sv
// ---------------------------------------------------------------------------
// frame_debouncer
// Whole-frame debouncer. A frame is committed to the stable key state only
// after DEBOUNCE further identical frames, and only while no events from the
// previous commit are still waiting to be emitted.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   frame_done_i      a complete scan frame is presented this cycle
//   frame_i           the complete frame (1 = pressed)
//   clr_mask_i        pending bits accepted by the consumer this cycle
//   keys_o            registered stable key state
//   keys_next_o       next-cycle stable key state
//   pending_next_o    next-cycle pending event mask
// ---------------------------------------------------------------------------
module frame_debouncer
  import key_matrix_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_done_i,
  input  logic [NUM_KEYS-1:0] frame_i,
  input  logic [NUM_KEYS-1:0] clr_mask_i,
  output logic [NUM_KEYS-1:0] keys_o,
  output logic [NUM_KEYS-1:0] keys_next_o,
  output logic [NUM_KEYS-1:0] pending_next_o
);

  localparam int               CNT_W   = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Stability count, commit decision and pending-mask bookkeeping.
  always_comb begin
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    keys_d    = keys_q;
    pending_d = pending_q & ~clr_mask_i;
    if (frame_done_i) begin
      prev_d = frame_i;
      if (frame_i != prev_q) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
      // The count saturates, so a frame blocked by outstanding events stays
      // eligible and commits on the first completion after pending drains.
      if ((cnt_d == CNT_MAX) && (frame_i != keys_q) && (pending_q == '0)) begin
        keys_d    = frame_i;
        pending_d = frame_i ^ keys_q;
      end else begin
        keys_d = keys_q;
      end
    end else begin
      prev_d = prev_q;
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q    <= '0;
      cnt_q     <= '0;
      keys_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      keys_q    <= keys_d;
      pending_q <= pending_d;
    end
  end

  assign keys_o         = keys_q;
  assign keys_next_o    = keys_d;
  assign pending_next_o = pending_d;

endmodule

// File: rtl/key_matrix_scanner.sv
// ---------------------------------------------------------------------------
// key_matrix_scanner
// Scans a 4x4 push-button matrix by strobing rows and sampling columns,
// debounces complete scan frames and emits press/release events one at a
// time over a valid/ready handshake.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   row_pins  row strobes, active-low one-hot (bit r low drives row r)
//   col_pins  column sense, active-low, asynchronous to clk
//   keys      debounced key state, bit row*COLS+col, 1 = pressed
//   evt       key event handshake (master side)
//
// Parameters:
//   SCAN_DIV  clocks each row is driven; >= 3 covers pin settle + sync
//   DEBOUNCE  further identical frames needed before a commit
// ---------------------------------------------------------------------------
module key_matrix_scanner
  import key_matrix_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ROWS-1:0]      row_pins,
  input  logic [COLS-1:0]      col_pins,
  output logic [NUM_KEYS-1:0]  keys,
  key_matrix_scanner_if.master evt
);

  localparam int              DW_W       = $clog2(SCAN_DIV);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(ROWS - 1);

  // Column synchronizer and decoded columns (1 = pressed).
  logic [COLS-1:0]      sync1_q, sync2_q;
  logic [COLS-1:0]      col_s;

  // Scan sequencer.
  logic                 run_q, run_d;
  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic [DW_W-1:0]      dwell_q, dwell_d;
  logic [ROWS-1:0]      row_pins_q, row_pins_d;
  logic [NUM_KEYS-1:0]  frame_q, frame_d, frame_s;
  logic                 last_dwell_s, frame_done_s;

  // Debouncer interface.
  logic [NUM_KEYS-1:0]  keys_s, keys_next_s, pending_next_s, clr_mask_s;

  // Event emitter.
  logic                 valid_q, valid_d;
  logic [KEY_IDX_W-1:0] code_q, code_d, nxt_idx_s;
  logic                 press_q, press_d;
  logic                 hs_s;

  // Two-flop synchronizer; resets to all-high, i.e. every column released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= {COLS{1'b1}};
      sync2_q <= {COLS{1'b1}};
    end else begin
      sync1_q <= col_pins;
      sync2_q <= sync1_q;
    end
  end

  assign col_s = ~sync2_q;

  // Row/dwell sequencing and frame assembly.
  always_comb begin
    run_d      = 1'b1;
    row_d      = row_q;
    dwell_d    = dwell_q;
    row_pins_d = row_pins_q;
    frame_d    = frame_q;
    frame_s    = frame_q;
    frame_s[row_q*COLS +: COLS] = col_s;
    last_dwell_s = run_q && (dwell_q == DWELL_LAST);
    frame_done_s = last_dwell_s && (row_q == ROW_LAST);
    if (!run_q) begin
      // First clock after reset: start driving row 0 with dwell at 0, so
      // every row gets exactly SCAN_DIV driven clocks.
      row_pins_d = row_strobe(row_q);
    end else if (last_dwell_s) begin
      dwell_d    = '0;
      row_d      = row_q + 1'b1;  // ROWS is a power of two, so this wraps 3->0
      row_pins_d = row_strobe(row_d);
      frame_d    = frame_s;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  // Scan sequencer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      row_q      <= '0;
      dwell_q    <= '0;
      row_pins_q <= {ROWS{1'b1}};
      frame_q    <= '0;
    end else begin
      run_q      <= run_d;
      row_q      <= row_d;
      dwell_q    <= dwell_d;
      row_pins_q <= row_pins_d;
      frame_q    <= frame_d;
    end
  end

  frame_debouncer #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debouncer (
    .clk           (clk),
    .rst           (rst),
    .frame_done_i  (frame_done_s),
    .frame_i       (frame_s),
    .clr_mask_i    (clr_mask_s),
    .keys_o        (keys_s),
    .keys_next_o   (keys_next_s),
    .pending_next_o(pending_next_s)
  );

  // Event selection. Looking at the debouncer's next-state mask lets an event
  // appear the cycle right after a commit and lets back-to-back events follow
  // a handshake without a bubble.
  always_comb begin
    hs_s       = valid_q && evt.key_ready;
    clr_mask_s = hs_s ? key_onehot(code_q) : '0;
    nxt_idx_s  = lowest_set(pending_next_s);
    valid_d    = valid_q;
    code_d     = code_q;
    press_d    = press_q;
    if (!valid_q || hs_s) begin
      if (pending_next_s != '0) begin
        valid_d = 1'b1;
        code_d  = nxt_idx_s;
        press_d = keys_next_s[nxt_idx_s];
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      // Held stable under backpressure.
      valid_d = valid_q;
    end
  end

  // Event output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      press_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      press_q <= press_d;
    end
  end

  assign row_pins      = row_pins_q;
  assign keys          = keys_s;
  assign evt.key_valid = valid_q;
  assign evt.key_code  = code_q;
  assign evt.key_press = press_q;

endmodule
